// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue: buffers ROB issue packets in a FIFO and presents one
// per cycle to the ALU. Optional macro ALU_IQ_BYPASS_EN: empty-queue bypass to the output.
package alu_iq_pkg;
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [5:0]  dest_reg_phys;
        logic [4:0]  rob_tag;
        logic [31:0] src_a;
        logic [31:0] src_b;
    } rob_issue;
endpackage

module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  rob_issue                   rob_insn_in,
    output logic                       in_ready_out,
    input  logic                       alu_ready_in,
    output rob_issue                   alu_insn_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rob_issue        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            enq;
    logic            pop;
    logic            byp;
    logic            wr;
    rob_issue        issue_pkt;

    // Readiness depends only on the registered count, so a pop never frees a slot early.
    assign in_ready_out = ~rst_in & (count < CW'(DEPTH));
    assign enq          = rob_insn_in.valid & in_ready_out & ~flush_in;
    assign pop          = ~flush_in & alu_ready_in & (count != '0);
`ifdef ALU_IQ_BYPASS_EN
    assign byp          = ~flush_in & enq & alu_ready_in & (count == '0);
`else
    assign byp          = 1'b0;
`endif
    assign wr           = enq & ~byp;
    assign count_out    = count;

    always_comb begin
        issue_pkt       = byp ? rob_insn_in : mem[head];
        issue_pkt.valid = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (wr) begin
            mem[tail] <= rob_insn_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            alu_insn_out <= '0;
        end else if (flush_in) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            alu_insn_out.valid <= 1'b0;
        end else begin
            if (wr) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            // Payload is only meaningful while valid, so it is left stale otherwise.
            if (pop || byp) begin
                alu_insn_out <= issue_pkt;
            end else begin
                alu_insn_out.valid <= 1'b0;
            end
            count <= count + CW'(wr) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = $bits(rob_issue);

    logic     clk_in = 1'b0;
    logic     rst_in;
    logic     flush_in;
    logic     alu_ready_in;
    logic     in_ready_out;
    rob_issue rob_insn_in;
    rob_issue alu_insn_out;
    logic [2:0] count_out;

    always #5 clk_in = ~clk_in;

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_in     (flush_in),
        .rob_insn_in  (rob_insn_in),
        .in_ready_out (in_ready_out),
        .alu_ready_in (alu_ready_in),
        .alu_insn_out (alu_insn_out),
        .count_out    (count_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: queue contents and the expected registered output.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] src_q[$];
    rob_issue     exp_out;
    logic         exp_valid;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rob_issue rand_pkt();
        rob_issue p;
        p.valid         = 1'b1;
        p.opcode        = 4'($urandom_range(0, 15));
        p.dest_reg_phys = 6'($urandom_range(0, 63));
        p.rob_tag       = 5'($urandom_range(0, 31));
        p.src_a         = $urandom;
        p.src_b         = $urandom;
        return p;
    endfunction

    task automatic cycle(input logic rdy, input logic fl, input logic src_en);
        rob_issue pkt;
        logic     mdl_ready;
        logic     accepted;
        pkt = '0;
        if (src_en && src_q.size() > 0) pkt = rob_issue'(src_q[0]);
        rob_insn_in  = pkt;
        alu_ready_in = rdy;
        flush_in     = fl;
        #1;
        mdl_ready = exp_q.size() < DEPTH;
        check("in_ready", W'(in_ready_out), W'(mdl_ready));
        accepted = pkt.valid && mdl_ready && !fl;
        @(posedge clk_in);
        if (fl) begin
            exp_q.delete();
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (rdy && exp_q.size() > 0) begin
                exp_out   = rob_issue'(exp_q.pop_front());
                exp_valid = 1'b1;
                if (accepted) exp_q.push_back(pkt);
            end
`ifdef ALU_IQ_BYPASS_EN
            else if (rdy && accepted && exp_q.size() == 0) begin
                exp_out   = pkt;
                exp_valid = 1'b1;
            end
`endif
            else if (accepted) begin
                exp_q.push_back(pkt);
            end
        end
        // The ROB drops its own copy on a squash as well.
        if (accepted || (fl && pkt.valid)) void'(src_q.pop_front());
        #1;
        check("out_valid", W'(alu_insn_out.valid), W'(exp_valid));
        check("count", W'(count_out), W'(exp_q.size()));
        if (exp_valid) check("out_pkt", alu_insn_out, exp_out);
    endtask

    initial begin
        rob_issue p;
        int       guard;
        rst_in       = 1'b1;
        flush_in     = 1'b0;
        alu_ready_in = 1'b0;
        rob_insn_in  = '0;
        exp_valid    = 1'b0;
        exp_out      = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_valid", W'(alu_insn_out.valid), W'(0));
        check("rst_count", W'(count_out), W'(0));
        check("rst_ready", W'(in_ready_out), W'(0));
        rst_in = 1'b0;

        // Reset asserted mid-stream with 3 queued
        for (int i = 0; i < 3; i++) src_q.push_back(rand_pkt());
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        check("pre_rst_count", W'(count_out), W'(3));
        rst_in = 1'b1;
        #1;
        check("mid_rst_count", W'(count_out), W'(0));
        check("mid_rst_ready", W'(in_ready_out), W'(0));
        check("mid_rst_valid", W'(alu_insn_out.valid), W'(0));
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        src_q.delete();
        exp_valid = 1'b0;
        #1;
        check("post_rst_ready", W'(in_ready_out), W'(1));
        check("post_rst_count", W'(count_out), W'(0));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Single ADD to an empty queue
        p = rand_pkt();
        p.opcode = 4'd0;
        p.dest_reg_phys = 6'd5;
        src_q.push_back(p);
        cycle(1'b1, 1'b0, 1'b1);
`ifndef ALU_IQ_BYPASS_EN
        check("add_lat_not_yet", W'(alu_insn_out.valid), W'(0));
        cycle(1'b1, 1'b0, 1'b1);
`endif
        check("add_valid", W'(alu_insn_out.valid), W'(1));
        check("add_dest", W'(alu_insn_out.dest_reg_phys), W'(5));
        cycle(1'b1, 1'b0, 1'b1);
        check("add_one_cycle", W'(alu_insn_out.valid), W'(0));

        // Fill past DEPTH with ALU stalled, then drain
        for (int i = 0; i < 5; i++) src_q.push_back(rand_pkt());
        repeat (6) cycle(1'b0, 1'b0, 1'b1);
        check("full_count", W'(count_out), W'(DEPTH));
        check("full_ready", W'(in_ready_out), W'(0));
        check("fifth_held", W'(src_q.size()), W'(1));
        repeat (8) cycle(1'b1, 1'b0, 1'b1);

        // Alternating ALU ready with 4 queued
        for (int i = 0; i < 4; i++) src_q.push_back(rand_pkt());
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'(~i & 1), 1'b0, 1'b0);

        // Flush with two queued and a same-cycle packet
        for (int i = 0; i < 3; i++) src_q.push_back(rand_pkt());
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        check("pre_flush_count", W'(count_out), W'(2));
        cycle(1'b1, 1'b1, 1'b1);
        check("flush_count", W'(count_out), W'(0));
        check("flush_valid", W'(alu_insn_out.valid), W'(0));
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Long random stream through wrapping pointers
        for (int i = 0; i < 100; i++) src_q.push_back(rand_pkt());
        guard = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'b0, 1'(exp_q.size() < 3 || $urandom_range(0, 1) == 1));
            guard++;
        end
        check("drain_timeout", W'(guard < 2000), W'(1));
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
